// File: rtl/gf180mcu_osu_sc_12t_muxn_pipe.sv
// gf180mcu_osu_sc_12t_muxn_pipe: N:1 registered channel mux with valid/ready handshake
// and either fixed (Sel) or round-robin channel grant.
module gf180mcu_osu_sc_12t_muxn_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int RR    = 0
) (
    input  logic                   CLK,
    input  logic                   RN,
    input  logic [NCH*WIDTH-1:0]   A,
    input  logic [NCH-1:0]         AV,
    output logic [NCH-1:0]         AR,
    input  logic [SELW-1:0]        Sel,
    output logic [WIDTH-1:0]       Y,
    output logic                   YV,
    input  logic                   YR,
    output logic [SELW-1:0]        Cur
);
    logic [SELW-1:0]  ptr, g;
    logic             gv, open, acc;
    logic [WIDTH-1:0] d;

    // Round-robin search runs from the highest offset down so the nearest one to ptr wins.
    always_comb begin
        g  = Cur;
        gv = int'(Cur) < NCH;
        if (RR != 0) begin
            g  = '0;
            gv = |AV;
            for (int i = NCH - 1; i >= 0; i--)
                if (AV[(int'(ptr) + i) % NCH]) g = SELW'((int'(ptr) + i) % NCH);
        end
    end

    assign open = !YV || YR;
    assign AR   = (RN && open && gv) ? (NCH'(1) << g) : '0;
    assign acc  = |(AR & AV);

    // Only the granted channel's data is ever muxed toward Y.
    always_comb begin
        d = '0;
        for (int k = 0; k < NCH; k++)
            if (AR[k]) d = A[k*WIDTH +: WIDTH];
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            Y   <= '0;
            YV  <= 1'b0;
            Cur <= '0;
            ptr <= '0;
        end else begin
            if (acc) begin
                Y  <= d;
                YV <= 1'b1;
            end else if (YR) begin
                YV <= 1'b0;
            end
            if (RR == 0) begin
                Cur <= Sel;
            end else if (acc) begin
                Cur <= g;
                ptr <= (int'(g) == NCH - 1) ? '0 : g + 1'b1;
            end
        end
    end
endmodule
